// File: rtl/lisnoc_dma_wb_arbiter.sv
// -----------------------------------------------------------------------------
// lisnoc_dma_wb_arbiter
//
// Merges the Wishbone ports of several DMA engines (initiator request,
// initiator response, target, ...) onto the single Wishbone master that
// leads to the tile bus. Arbitration is fixed priority (index 0 highest) or
// round robin. An optional beat limit lets a long-running engine be
// preempted at a transfer boundary, so that no engine starves the others.
//
// Parameters
//   NUM_MASTERS  number of requesting masters (>= 2)
//   ADDR_WIDTH   Wishbone address width
//   DATA_WIDTH   Wishbone data width (multiple of 8)
//   ARB_MODE     0 = fixed priority, 1 = round robin
//   MAX_BEATS    acked beats before preemption is allowed, 0 = never preempt
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   m_*_i              flattened per-master request fields, master i at slice i
//   m_ack_o            ack routed to the granted master only
//   m_dat_o            read data, broadcast to all masters
//   wb_*_o             muxed bus towards the slave, all zero when no grant
//   wb_cab_o           tied low
//   wb_dat_i/wb_ack_i  slave read data and acknowledge
//   grant_o            registered one-hot grant, zero when idle or in the gap
// -----------------------------------------------------------------------------
module lisnoc_dma_wb_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ARB_MODE    = 0,
  parameter int MAX_BEATS   = 0,
  localparam int SEL_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
  input  logic [NUM_MASTERS*3-1:0]          m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]          m_bte_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [ADDR_WIDTH-1:0]             wb_adr_o,
  output logic [DATA_WIDTH-1:0]             wb_dat_o,
  output logic [SEL_WIDTH-1:0]              wb_sel_o,
  output logic [2:0]                        wb_cti_o,
  output logic [1:0]                        wb_bte_o,
  output logic                              wb_cyc_o,
  output logic                              wb_stb_o,
  output logic                              wb_we_o,
  output logic                              wb_cab_o,
  input  logic [DATA_WIDTH-1:0]             wb_dat_i,
  input  logic                              wb_ack_i,
  output logic [NUM_MASTERS-1:0]            grant_o
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GAP
  } state_t;

  state_t                 state_q, state_d;
  // Granted master while BUSY; holds the latched winner while in GAP.
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       rrPtr_q, rrPtr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;

  logic                   busy;
  logic [NUM_MASTERS-1:0] gOneHot;
  logic [NUM_MASTERS-1:0] others;
  logic                   beat;
  logic [CNT_W-1:0]       countAfter;
  logic                   atBoundary;
  logic                   preempt;

  // Fixed mode picks the lowest set index. Round robin scans starting just
  // after the pointer; iterating k downwards lets the nearest candidate win.
  function automatic logic [IDX_W-1:0] arb(input logic [NUM_MASTERS-1:0] cand,
                                            input logic [IDX_W-1:0] ptr);
    int j;
    arb = '0;
    if (ARB_MODE == 0) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (cand[i]) arb = IDX_W'(i);
      end
    end else begin
      for (int k = NUM_MASTERS; k >= 1; k--) begin
        j = (int'(ptr) + k) % NUM_MASTERS;
        if (cand[j]) arb = IDX_W'(j);
      end
    end
  endfunction

  assign busy    = (state_q == BUSY);
  assign gOneHot = NUM_MASTERS'(1) << idx_q;
  assign others  = m_cyc_i & ~gOneHot;

  // Bus mux: a pure combinational path from the granted master, so the
  // slave sees requests with no extra latency. Outside BUSY everything is 0.
  always_comb begin
    wb_adr_o = '0;
    wb_dat_o = '0;
    wb_sel_o = '0;
    wb_cti_o = '0;
    wb_bte_o = '0;
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    if (busy) begin
      wb_adr_o = m_adr_i[int'(idx_q)*ADDR_WIDTH +: ADDR_WIDTH];
      wb_dat_o = m_dat_i[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
      wb_sel_o = m_sel_i[int'(idx_q)*SEL_WIDTH +: SEL_WIDTH];
      wb_cti_o = m_cti_i[int'(idx_q)*3 +: 3];
      wb_bte_o = m_bte_i[int'(idx_q)*2 +: 2];
      wb_cyc_o = m_cyc_i[idx_q];
      wb_stb_o = m_stb_i[idx_q];
      wb_we_o  = m_we_i[idx_q];
    end
  end

  assign m_ack_o  = busy ? (gOneHot & {NUM_MASTERS{wb_ack_i}}) : '0;
  assign m_dat_o  = wb_dat_i;
  assign wb_cab_o = 1'b0;
  assign grant_o  = grant_q;

  // Beat counter value including the current beat; it saturates so that an
  // engine running alone stays eligible for preemption at every boundary.
  assign beat       = wb_ack_i & wb_stb_o;
  assign countAfter = (beat && (count_q != CNT_MAX)) ? count_q + CNT_W'(1) : count_q;
  assign atBoundary = (wb_cti_o == 3'b000) || (wb_cti_o == 3'b111);
  assign preempt    = (MAX_BEATS > 0) && (countAfter >= CNT_MAX) && wb_ack_i &&
                      atBoundary && (|others);

  // Next-state logic. A release is checked before preemption so that an
  // engine leaving at a boundary hands over directly without a gap cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rrPtr_d = rrPtr_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (|m_cyc_i) begin
          state_d = BUSY;
          idx_d   = arb(m_cyc_i, rrPtr_q);
          rrPtr_d = idx_d;
        end
      end
      BUSY: begin
        if (!m_cyc_i[idx_q]) begin
          count_d = '0;
          if (|m_cyc_i) begin
            idx_d   = arb(m_cyc_i, rrPtr_q);
            rrPtr_d = idx_d;
          end else begin
            state_d = IDLE;
          end
        end else if (preempt) begin
          state_d = GAP;
          idx_d   = arb(others, rrPtr_q);
          rrPtr_d = idx_d;
          count_d = '0;
        end else begin
          count_d = countAfter;
        end
      end
      GAP: begin
        state_d = BUSY;
        count_d = '0;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  assign grant_d = (state_d == BUSY) ? (NUM_MASTERS'(1) << idx_d) : '0;

  // State registers; reset drops any in-flight beat and forces the bus idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rrPtr_q <= IDX_W'(NUM_MASTERS - 1);
      count_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rrPtr_q <= rrPtr_d;
      count_q <= count_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: tb/tb_lisnoc_dma_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lisnoc_dma_wb_arbiter
//
// Two arbiter instances share one set of master/slave stimulus: instance 0 is
// fixed priority with a 4-beat limit, instance 1 is round robin with a 3-beat
// limit. A behavioural model per instance tracks owner / pending winner /
// beat count and predicts every output each cycle. Directed sequences cover
// the handover, round-robin, preemption, burst, reset and stray-ack cases,
// followed by a long randomized run.
// -----------------------------------------------------------------------------
module tb_lisnoc_dma_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int BW = 3 + 3 + 2 + SW + AW + DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N*AW-1:0] mAdr;
  logic [N*DW-1:0] mDat;
  logic [N*SW-1:0] mSel;
  logic [N*3-1:0]  mCti;
  logic [N*2-1:0]  mBte;
  logic [N-1:0]    mCyc, mStb, mWe;
  logic [DW-1:0]   wbDatIn;
  logic            wbAckIn;

  logic [N-1:0]    mAck     [2];
  logic [DW-1:0]   mDatOut  [2];
  logic [AW-1:0]   wbAdr    [2];
  logic [DW-1:0]   wbDatOut [2];
  logic [SW-1:0]   wbSel    [2];
  logic [2:0]      wbCti    [2];
  logic [1:0]      wbBte    [2];
  logic            wbCyc    [2];
  logic            wbStb    [2];
  logic            wbWe     [2];
  logic            wbCab    [2];
  logic [N-1:0]    grant    [2];

  lisnoc_dma_wb_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(0), .MAX_BEATS(4)
  ) dutFixed (
    .clk(clk), .rst(rst),
    .m_adr_i(mAdr), .m_dat_i(mDat), .m_sel_i(mSel), .m_cti_i(mCti), .m_bte_i(mBte),
    .m_cyc_i(mCyc), .m_stb_i(mStb), .m_we_i(mWe),
    .m_ack_o(mAck[0]), .m_dat_o(mDatOut[0]),
    .wb_adr_o(wbAdr[0]), .wb_dat_o(wbDatOut[0]), .wb_sel_o(wbSel[0]), .wb_cti_o(wbCti[0]),
    .wb_bte_o(wbBte[0]), .wb_cyc_o(wbCyc[0]), .wb_stb_o(wbStb[0]), .wb_we_o(wbWe[0]),
    .wb_cab_o(wbCab[0]), .wb_dat_i(wbDatIn), .wb_ack_i(wbAckIn), .grant_o(grant[0])
  );

  lisnoc_dma_wb_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(1), .MAX_BEATS(3)
  ) dutRr (
    .clk(clk), .rst(rst),
    .m_adr_i(mAdr), .m_dat_i(mDat), .m_sel_i(mSel), .m_cti_i(mCti), .m_bte_i(mBte),
    .m_cyc_i(mCyc), .m_stb_i(mStb), .m_we_i(mWe),
    .m_ack_o(mAck[1]), .m_dat_o(mDatOut[1]),
    .wb_adr_o(wbAdr[1]), .wb_dat_o(wbDatOut[1]), .wb_sel_o(wbSel[1]), .wb_cti_o(wbCti[1]),
    .wb_bte_o(wbBte[1]), .wb_cyc_o(wbCyc[1]), .wb_stb_o(wbStb[1]), .wb_we_o(wbWe[1]),
    .wb_cab_o(wbCab[1]), .wb_dat_i(wbDatIn), .wb_ack_i(wbAckIn), .grant_o(grant[1])
  );

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 1'b0;

  // Every comparison of the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // owner: granted master or -1; gapWin: winner waiting out the gap or -1.
  int modeOf [2] = '{0, 1};
  int maxOf  [2] = '{4, 3};
  int owner  [2] = '{-1, -1};
  int gapWin [2] = '{-1, -1};
  int beats  [2] = '{0, 0};
  int rrLast [2] = '{N - 1, N - 1};

  function automatic int pick(input logic [N-1:0] cand, input int mode, input int last);
    int j;
    pick = -1;
    for (int k = 1; k <= N; k++) begin
      j = (mode == 0) ? k - 1 : (last + k) % N;
      if (pick < 0 && cand[j]) pick = j;
    end
  endfunction

  function automatic logic [BW-1:0] busOf(input int o);
    busOf = {mCyc[o], mStb[o], mWe[o], mCti[o*3 +: 3], mBte[o*2 +: 2],
             mSel[o*SW +: SW], mAdr[o*AW +: AW], mDat[o*DW +: DW]};
  endfunction

  task automatic stepModel(input int d);
    int nb;
    int w;
    logic [N-1:0] rest;
    logic [2:0] cti;
    if (rst) begin
      owner[d] = -1; gapWin[d] = -1; beats[d] = 0; rrLast[d] = N - 1;
    end else if (gapWin[d] >= 0) begin
      owner[d] = gapWin[d]; gapWin[d] = -1; beats[d] = 0;
    end else if (owner[d] < 0 || !mCyc[owner[d]]) begin
      w = pick(mCyc, modeOf[d], rrLast[d]);
      owner[d] = w;
      if (w >= 0) rrLast[d] = w;
      beats[d] = 0;
    end else begin
      nb = beats[d] + ((wbAckIn && mStb[owner[d]]) ? 1 : 0);
      if (nb > maxOf[d]) nb = maxOf[d];
      rest = mCyc;
      rest[owner[d]] = 1'b0;
      cti = mCti[owner[d]*3 +: 3];
      if (maxOf[d] > 0 && nb >= maxOf[d] && wbAckIn && (cti == 3'd0 || cti == 3'd7) &&
          rest != '0) begin
        gapWin[d] = pick(rest, modeOf[d], rrLast[d]);
        rrLast[d] = gapWin[d];
        owner[d]  = -1;
        beats[d]  = 0;
      end else begin
        beats[d] = nb;
      end
    end
  endtask

  logic [BW-1:0] expBus;
  logic [N-1:0]  expGnt;
  logic [N-1:0]  expAck;

  // Compare both instances against the model mid-cycle, then advance the
  // model with the inputs that the coming rising edge will sample.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (owner[d] >= 0) begin
        expBus = busOf(owner[d]);
        expGnt = N'(1) << owner[d];
        expAck = wbAckIn ? expGnt : '0;
      end else begin
        expBus = '0;
        expGnt = '0;
        expAck = '0;
      end
      if (checkEn) begin
        checkOutput($sformatf("grant dut%0d", d), grant[d], expGnt);
        checkOutput($sformatf("bus dut%0d", d),
                    {wbCyc[d], wbStb[d], wbWe[d], wbCti[d], wbBte[d], wbSel[d], wbAdr[d],
                     wbDatOut[d]}, expBus);
        checkOutput($sformatf("m_ack dut%0d", d), mAck[d], expAck);
        checkOutput($sformatf("m_dat dut%0d", d), mDatOut[d], wbDatIn);
        checkOutput($sformatf("cab dut%0d", d), wbCab[d], 1'b0);
      end
      stepModel(d);
    end
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input logic [N-1:0] cyc, input logic [N-1:0] stb,
                               input logic [N*3-1:0] cti, input logic ack);
    @(posedge clk);
    #1;
    mCyc    = cyc;
    mStb    = stb;
    mCti    = cti;
    wbAckIn = ack;
    for (int i = 0; i < N; i++) begin
      mAdr[i*AW +: AW] = $urandom;
      mDat[i*DW +: DW] = $urandom;
      mSel[i*SW +: SW] = SW'($urandom);
      mBte[i*2 +: 2]   = 2'($urandom);
      mWe[i]           = 1'($urandom);
    end
    wbDatIn = $urandom;
  endtask

  logic [N-1:0] expSeq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [N-1:0] rCyc, rStb;
  logic [N*3-1:0] rCti;
  int acks;
  int g;
  bit found;
  bit done;

  initial begin
    rst = 1'b1;
    mCyc = '0; mStb = '0; mWe = '0; mCti = '0; mBte = '0; mSel = '0; mAdr = '0; mDat = '0;
    wbAckIn = 1'b0; wbDatIn = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkEn = 1'b1;
    @(negedge clk);
    checkOutput("reset grant", grant[0], 3'b000);
    checkOutput("reset cyc", wbCyc[0], 1'b0);

    // T1: simultaneous requests from IDLE, then release hands over directly.
    applyStimulus(3'b101, 3'b101, '0, 1'b0);
    @(negedge clk);
    checkOutput("T1 idle latency", grant[0], 3'b000);
    applyStimulus(3'b101, 3'b101, '0, 1'b0);
    @(negedge clk);
    checkOutput("T1 first grant", grant[0], 3'b001);
    applyStimulus(3'b100, 3'b100, '0, 1'b0);
    @(negedge clk);
    checkOutput("T1 release cycle cyc", wbCyc[0], 1'b0);
    applyStimulus(3'b100, 3'b100, '0, 1'b0);
    @(negedge clk);
    checkOutput("T1 handover", grant[0], 3'b100);
    repeat (2) applyStimulus('0, '0, '0, 1'b0);

    // T2: round robin, each master leaves after one acked beat.
    applyStimulus(3'b111, 3'b111, '0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      found = 1'b0;
      for (int t = 0; t < 10 && !found; t++) begin
        @(negedge clk);
        if (grant[1] != '0) found = 1'b1;
      end
      checkOutput("T2 grant wait", found, 1'b1);
      checkOutput($sformatf("T2 grant %0d", s), grant[1], expSeq[s]);
      g = 0;
      for (int i = 0; i < N; i++) if (grant[1][i]) g = i;
      applyStimulus(3'b111, 3'b111, '0, 1'b1);
      applyStimulus(3'b111 & ~(N'(1) << g), 3'b111 & ~(N'(1) << g), '0, 1'b0);
      applyStimulus(3'b111, 3'b111, '0, 1'b0);
    end
    repeat (2) applyStimulus('0, '0, '0, 1'b0);

    // T3: singles from m0 with m1 waiting; preempted after the 4th ack.
    applyStimulus(3'b011, 3'b011, '0, 1'b1);
    acks = 0;
    for (int t = 0; t < 20 && acks < 4; t++) begin
      @(negedge clk);
      if (mAck[0][0]) acks++;
    end
    checkOutput("T3 acks before preempt", acks, 4);
    applyStimulus(3'b011, 3'b011, '0, 1'b1);
    @(negedge clk);
    checkOutput("T3 gap cyc", wbCyc[0], 1'b0);
    checkOutput("T3 gap grant", grant[0], 3'b000);
    applyStimulus(3'b011, 3'b011, '0, 1'b1);
    @(negedge clk);
    checkOutput("T3 m1 grant", grant[0], 3'b010);
    checkOutput("T3 m0 no ack", mAck[0][0], 1'b0);
    repeat (2) applyStimulus('0, '0, '0, 1'b0);

    // T4: 8-beat incrementing burst is only preempted after its last beat.
    applyStimulus(3'b011, 3'b011, {N{3'b010}}, 1'b1);
    acks = 0;
    done = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (grant[0] == 3'b001 && mAck[0][0]) acks++;
      if (grant[0] == 3'b010) done = 1'b1;
      else applyStimulus(3'b011, 3'b011, {N{(acks == 7) ? 3'b111 : 3'b010}}, 1'b1);
    end
    checkOutput("T4 handover seen", done, 1'b1);
    checkOutput("T4 burst beats", acks, 8);
    repeat (2) applyStimulus('0, '0, '0, 1'b0);

    // T5: reset in the middle of an acked beat.
    applyStimulus(3'b001, 3'b001, '0, 1'b1);
    applyStimulus(3'b001, 3'b001, '0, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("T5 grant", grant[0], 3'b000);
    checkOutput("T5 cyc", wbCyc[0], 1'b0);
    checkOutput("T5 ack", mAck[0], 3'b000);
    checkOutput("T5 grant rr", grant[1], 3'b000);

    // T6: stray acks while idle never reach a master.
    repeat (2) applyStimulus('0, '0, '0, 1'b0);
    applyStimulus('0, '0, '0, 1'b1);
    @(negedge clk);
    checkOutput("T6 idle ack", mAck[0], 3'b000);

    // Randomized traffic with occasional resets.
    rCyc = '0;
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rCyc[i]) begin
          if ($urandom_range(5) == 0) rCyc[i] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          rCyc[i] = 1'b1;
        end
        rStb[i] = rCyc[i] && ($urandom_range(7) != 0);
        case ($urandom_range(2))
          0:       rCti[i*3 +: 3] = 3'b000;
          1:       rCti[i*3 +: 3] = 3'b010;
          default: rCti[i*3 +: 3] = 3'b111;
        endcase
      end
      applyStimulus(rCyc, rStb, rCti, 1'($urandom_range(1)));
      rst = ($urandom_range(149) == 0);
    end
    applyStimulus('0, '0, '0, 1'b0);
    rst = 1'b0;
    applyStimulus('0, '0, '0, 1'b0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
